// File: rtl/cpu_controller.sv
// Multi-cycle controller for a 4-register, 8-bit accumulator-style CPU.
// Sequences FETCH/DECODE/EXECUTE|IMM/WRITEBACK and drives the register-file and PC strobes.
module cpu_controller #(
   parameter logic [7:0] PC_MAX = 8'h06
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] pc,
   input  logic [7:0] instr_data,
   input  logic [7:0] read_data1,
   input  logic [7:0] read_data2,
   output logic       pc_write_enable,
   output logic [1:0] read_addr1,
   output logic [1:0] read_addr2,
   output logic       write_enable,
   output logic [1:0] write_addr,
   output logic [7:0] write_data,
   output logic       zero_flag,
   output logic       carry_flag,
   output logic       halted,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      StFetch     = 3'd0,
      StDecode    = 3'd1,
      StExecute   = 3'd2,
      StImm       = 3'd3,
      StWriteback = 3'd4,
      StHalt      = 3'd5
   } state_e;

   state_e     state_q;
   logic [7:0] ir_q;
   logic [7:0] fetch_pc_q;  // address of the most recently consumed byte (opcode or immediate)
   logic [7:0] result_q;
   logic       zero_q;
   logic       carry_q;

   logic [3:0] opcode;
   logic [1:0] rd;
   logic [1:0] rs;
   logic       is_alu;
   logic       writes_reg;
   logic [8:0] sum;
   logic [7:0] alu_res;
   logic       alu_carry;

   assign opcode     = ir_q[7:4];
   assign rd         = ir_q[3:2];
   assign rs         = ir_q[1:0];
   assign is_alu     = (opcode >= 4'h2) && (opcode <= 4'h6);
   assign writes_reg = (opcode != 4'h0) && (opcode <= 4'h7);

   always_comb begin
      sum       = {1'b0, read_data1} + {1'b0, read_data2};
      alu_res   = 8'h00;
      alu_carry = 1'b0;
      case (opcode)
         4'h2: begin
            alu_res   = sum[7:0];
            alu_carry = sum[8];
         end
         4'h3: begin
            alu_res   = read_data1 - read_data2;
            alu_carry = (read_data2 > read_data1);
         end
         4'h4:    alu_res = read_data1 & read_data2;
         4'h5:    alu_res = read_data1 | read_data2;
         4'h6:    alu_res = read_data1 ^ read_data2;
         default: alu_res = 8'h00;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StFetch;
         ir_q       <= 8'h00;
         fetch_pc_q <= 8'h00;
         result_q   <= 8'h00;
         zero_q     <= 1'b0;
         carry_q    <= 1'b0;
      end else begin
         case (state_q)
            StFetch: begin
               ir_q       <= instr_data;
               fetch_pc_q <= pc;
               state_q    <= StDecode;
            end
            StDecode: begin
               if (opcode == 4'hF) begin
                  state_q <= StHalt;
               end else if (opcode == 4'h7) begin
                  // No immediate byte exists beyond the last address
                  state_q <= (fetch_pc_q == PC_MAX) ? StHalt : StImm;
               end else begin
                  state_q <= StExecute;
               end
            end
            StExecute: begin
               if (opcode == 4'h1) begin
                  result_q <= read_data2;
               end else if (is_alu) begin
                  result_q <= alu_res;
                  zero_q   <= (alu_res == 8'h00);
                  carry_q  <= alu_carry;
               end
               state_q <= StWriteback;
            end
            StImm: begin
               result_q   <= instr_data;
               fetch_pc_q <= pc;
               state_q    <= StWriteback;
            end
            StWriteback: begin
               state_q <= (fetch_pc_q == PC_MAX) ? StHalt : StFetch;
            end
            StHalt: begin
               state_q <= StHalt;
            end
            default: begin
               state_q <= StFetch;
            end
         endcase
      end
   end

   // Strobes are gated by reset so they read 0 while reset is held
   assign pc_write_enable = !reset && ((state_q == StFetch) || (state_q == StImm)) &&
                            (pc < PC_MAX);
   assign write_enable    = !reset && (state_q == StWriteback) && writes_reg;
   assign read_addr1      = rd;
   assign read_addr2      = rs;
   assign write_addr      = rd;
   assign write_data      = result_q;
   assign zero_flag       = zero_q;
   assign carry_flag      = carry_q;
   assign halted          = (state_q == StHalt);
   assign state           = state_q;

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: ROM/register-file environment, ISA-level reference model
// that queues expected register writes, and a monitor that checks every write strobe.
module tb_cpu_controller;

   localparam logic [7:0] PC_MAX = 8'h06;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] pc;
   logic [7:0] instr_data;
   logic [7:0] read_data1;
   logic [7:0] read_data2;
   logic       pc_write_enable;
   logic [1:0] read_addr1;
   logic [1:0] read_addr2;
   logic       write_enable;
   logic [1:0] write_addr;
   logic [7:0] write_data;
   logic       zero_flag;
   logic       carry_flag;
   logic       halted;
   logic [2:0] state;

   cpu_controller #(.PC_MAX(PC_MAX)) dut (
      .clk             (clk),
      .reset           (reset),
      .pc              (pc),
      .instr_data      (instr_data),
      .read_data1      (read_data1),
      .read_data2      (read_data2),
      .pc_write_enable (pc_write_enable),
      .read_addr1      (read_addr1),
      .read_addr2      (read_addr2),
      .write_enable    (write_enable),
      .write_addr      (write_addr),
      .write_data      (write_data),
      .zero_flag       (zero_flag),
      .carry_flag      (carry_flag),
      .halted          (halted),
      .state           (state)
   );

   always #5 clk = ~clk;

   // Environment: ROM, PC register and register file
   logic [7:0] rom [256];
   logic [7:0] regs [4];
   logic [7:0] init_regs [4];
   logic       load_en = 1'b0;

   always @(posedge clk or posedge reset) begin
      if (reset) pc <= 8'h00;
      else if (pc_write_enable) pc <= pc + 8'd1;
   end

   always @(posedge clk) begin
      if (load_en) begin
         for (int i = 0; i < 4; i++) regs[i] <= init_regs[i];
      end else if (write_enable) begin
         regs[write_addr] <= write_data;
      end
   end

   assign instr_data = rom[pc];
   assign read_data1 = regs[read_addr1];
   assign read_data2 = regs[read_addr2];

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Reference model: architectural state and expected write stream
   typedef struct packed {
      logic [1:0] addr;
      logic [7:0] data;
      logic       zf;
      logic       cf;
   } exp_t;

   exp_t       exp_q [$];
   logic [7:0] m_regs [4];
   logic       m_zf;
   logic       m_cf;
   logic [7:0] m_pc;

   task automatic m_write(input logic [1:0] rd, input logic [7:0] v);
      m_regs[rd] = v;
      exp_q.push_back('{addr: rd, data: v, zf: m_zf, cf: m_cf});
   endtask

   task automatic run_model(output int cycles);
      logic [7:0] a;
      logic [7:0] last;
      logic [7:0] ir;
      logic [3:0] op;
      logic [1:0] rd;
      logic [1:0] rs;
      logic [7:0] x;
      logic [7:0] y;
      logic [8:0] s;
      cycles = 0;
      a      = 8'h00;
      while (1) begin
         ir = rom[a];
         op = ir[7:4];
         rd = ir[3:2];
         rs = ir[1:0];
         x  = m_regs[rd];
         y  = m_regs[rs];
         if (op == 4'hF || (op == 4'h7 && a == PC_MAX)) begin
            cycles += 2;
            m_pc = (a < PC_MAX) ? a + 8'd1 : a;
            break;
         end
         last = a;
         case (op)
            4'h1: m_write(rd, y);
            4'h2: begin
               s = {1'b0, x} + {1'b0, y};
               m_cf = s[8];
               m_zf = (s[7:0] == 8'h00);
               m_write(rd, s[7:0]);
            end
            4'h3: begin
               m_cf = (y > x);
               m_zf = (x == y);
               m_write(rd, x - y);
            end
            4'h4: begin m_cf = 1'b0; m_zf = ((x & y) == 8'h00); m_write(rd, x & y); end
            4'h5: begin m_cf = 1'b0; m_zf = ((x | y) == 8'h00); m_write(rd, x | y); end
            4'h6: begin m_cf = 1'b0; m_zf = ((x ^ y) == 8'h00); m_write(rd, x ^ y); end
            4'h7: begin
               last = a + 8'd1;
               m_write(rd, rom[last]);
            end
            default: ;
         endcase
         cycles += 4;
         if (last == PC_MAX) begin
            m_pc = PC_MAX;
            break;
         end
         a = last + 8'd1;
      end
   endtask

   // Monitor: pops the scoreboard on every write strobe
   exp_t mon_e;
   always @(negedge clk) begin
      if (write_enable) begin
         check("strobe exclusive", 32'(pc_write_enable), 32'd0);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected write: addr %0h data %0h, none expected", write_addr,
                     write_data);
         end else begin
            mon_e = exp_q.pop_front();
            check("write_addr", 32'(write_addr), 32'(mon_e.addr));
            check("write_data", 32'(write_data), 32'(mon_e.data));
            check("zero at write", 32'(zero_flag), 32'(mon_e.zf));
            check("carry at write", 32'(carry_flag), 32'(mon_e.cf));
         end
      end
      if (halted) check("halt strobes", 32'({pc_write_enable, write_enable}), 32'd0);
   end

   task automatic check_reset(input string name);
      check({name, " rst pc_we"}, 32'(pc_write_enable), 32'd0);
      check({name, " rst outputs"}, 32'({read_addr1, read_addr2, write_enable, write_addr,
            write_data, zero_flag, carry_flag, halted}), 32'd0);
      check({name, " rst state"}, 32'(state), 32'd0);
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = 8'h00;
   endtask

   task automatic run_prog(input string name, input bit abort_exec, output int halt_k);
      int exp_cycles;
      int k;
      reset   = 1'b1;
      load_en = 1'b1;
      @(posedge clk);
      #1 load_en = 1'b0;
      @(negedge clk);
      check_reset(name);
      for (int i = 0; i < 4; i++) m_regs[i] = init_regs[i];
      m_zf = 1'b0;
      m_cf = 1'b0;
      if (abort_exec) begin
         reset = 1'b0;
         k     = 0;
         while (state !== 3'd2 && k < 50) begin
            @(negedge clk);
            k++;
         end
         check({name, " reach execute"}, 32'(state), 32'd2);
         reset = 1'b1;
         #1 check_reset({name, " abort"});
         @(negedge clk);
         check_reset({name, " abort held"});
      end
      run_model(exp_cycles);
      reset = 1'b0;
      #1 check({name, " fetch after release"}, 32'(state), 32'd0);
      k = 0;
      while (!halted && k < 200) begin
         @(negedge clk);
         k++;
      end
      halt_k = k;
      check({name, " halt cycle"}, 32'(k), 32'(exp_cycles));
      repeat (3) @(negedge clk);
      check({name, " halted stays"}, 32'(halted), 32'd1);
      check({name, " writes pending"}, 32'(exp_q.size()), 32'd0);
      check({name, " zero_flag"}, 32'(zero_flag), 32'(m_zf));
      check({name, " carry_flag"}, 32'(carry_flag), 32'(m_cf));
      check({name, " final pc"}, 32'(pc), 32'(m_pc));
      for (int i = 0; i < 4; i++) check({name, " reg"}, 32'(regs[i]), 32'(m_regs[i]));
      exp_q.delete();
   endtask

   initial begin
      int hk;
      for (int i = 0; i < 4; i++) init_regs[i] = 8'h00;
      clear_rom();

      // LDI/LDI/ADD/HALT example program
      rom[0] = 8'h70; rom[1] = 8'h05; rom[2] = 8'h74; rom[3] = 8'hFB;
      rom[4] = 8'h21; rom[5] = 8'hF0;
      run_prog("example", 1'b0, hk);
      check("example cycle 14", 32'(hk), 32'd14);
      check("example R0", 32'(regs[0]), 32'h00);
      check("example R1", 32'(regs[1]), 32'hFB);
      check("example flags", 32'({zero_flag, carry_flag}), 32'b11);

      // SUB with borrow
      clear_rom();
      init_regs[0] = 8'h03; init_regs[1] = 8'h05;
      rom[0] = 8'h31; rom[1] = 8'hF0;
      run_prog("sub", 1'b0, hk);
      check("sub R0", 32'(regs[0]), 32'hFE);
      check("sub flags", 32'({zero_flag, carry_flag}), 32'b01);

      // All NOPs run to PC_MAX then halt
      clear_rom();
      run_prog("nops", 1'b0, hk);
      check("nops cycles", 32'(hk), 32'd28);
      check("nops pc", 32'(pc), 32'h06);

      // LDI as the last byte halts without a write
      clear_rom();
      rom[6] = 8'h70;
      run_prog("ldi last", 1'b0, hk);
      check("ldi last cycles", 32'(hk), 32'd26);

      // Unused opcode behaves as NOP, flags preserved
      clear_rom();
      init_regs[0] = 8'hFF; init_regs[1] = 8'h01;
      rom[0] = 8'h21; rom[1] = 8'h9A; rom[2] = 8'hF0;
      run_prog("op9a", 1'b0, hk);
      check("op9a cycles", 32'(hk), 32'd10);
      check("op9a flags", 32'({zero_flag, carry_flag}), 32'b11);

      // Reset in the middle of an ADD
      clear_rom();
      init_regs[0] = 8'h10; init_regs[1] = 8'h20;
      rom[0] = 8'h21; rom[1] = 8'hF0;
      run_prog("abort", 1'b1, hk);
      check("abort R0", 32'(regs[0]), 32'h30);

      // Random programs
      for (int t = 0; t < 40; t++) begin
         clear_rom();
         for (int i = 0; i < 4; i++) init_regs[i] = 8'($urandom_range(0, 255));
         for (int i = 0; i <= 7; i++) rom[i] = 8'($urandom_range(0, 255));
         run_prog("random", 1'b0, hk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 SHALL have parameter PC_MAX, default 8'h06: last fetchable program address; the PC saturates here.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port pc  input  8  current program counter from the register file.
REQ-005 SHALL have port instr_data  input  8  instruction-ROM byte at address pc (combinational ROM).
REQ-006 SHALL have port read_data1  input  8  register-file data for read_addr1 (rd).
REQ-007 SHALL have port read_data2  input  8  register-file data for read_addr2 (rs).
REQ-008 SHALL have port pc_write_enable  output  1  one-cycle PC advance request.
REQ-009 SHALL have port read_addr1  output  2  rd field of IR.
REQ-010 SHALL have port read_addr2  output  2  rs field of IR.
REQ-011 SHALL have port write_enable  output  1  register write strobe.
REQ-012 SHALL have port write_addr  output  2  destination register (rd).
REQ-013 SHALL have port write_data  output  8  value to write (ALU result or immediate).
REQ-014 SHALL have port zero_flag  output  1  last ALU result == 0.
REQ-015 SHALL have port carry_flag  output  1  ADD carry-out / SUB borrow.
REQ-016 SHALL have port halted  output  1  high in HALT state.
REQ-017 SHALL have port state  output  3  FSM state encoding (debug).

Function
REQ-018 SHALL decode IR as opcode=IR[7:4], rd=IR[3:2], rs=IR[1:0].
REQ-019 SHALL support opcodes: 0 NOP, 1 MOV rd<-rs, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR (rd<-rd op rs), 7 LDI rd<-next byte, F HALT; 8-E SHALL execute as NOP.
REQ-020 SHALL implement states FETCH=0, DECODE=1, EXECUTE=2, IMM=3, WRITEBACK=4, HALT=5.
REQ-021 FETCH: SHALL latch instr_data into IR and pc into fetch_pc, and SHALL assert pc_write_enable only if pc < PC_MAX; next state DECODE.
REQ-022 DECODE: opcode F -> HALT; opcode 7 -> IMM, or HALT with no write if fetch_pc == PC_MAX; all others -> EXECUTE.
REQ-023 EXECUTE: SHALL register result (MOV: read_data2; ALU ops: read_data1 op read_data2, 8-bit wrap) and go to WRITEBACK.
REQ-024 IMM: SHALL latch instr_data as result, assert pc_write_enable if pc < PC_MAX, and go to WRITEBACK.
REQ-025 WRITEBACK: SHALL assert write_enable for exactly one cycle for opcodes 1-7 only, with write_addr=rd and write_data=result.
REQ-026 WRITEBACK: SHALL go to HALT if the last byte consumed was fetched at PC_MAX; otherwise it SHALL go to FETCH.
REQ-027 Every instruction other than HALT SHALL take exactly 4 cycles (FETCH to WRITEBACK inclusive).
REQ-028 Flags SHALL update at the end of EXECUTE for opcodes 2-6 only; MOV, LDI and NOP SHALL leave flags unchanged.
REQ-029 ADD carry SHALL equal bit 8 of the 9-bit sum; SUB carry SHALL be 1 iff read_data2 > read_data1; AND, OR and XOR SHALL clear carry.
REQ-030 HALT SHALL be terminal until reset, with halted=1 and pc_write_enable=0 and write_enable=0 every cycle.
REQ-031 write_enable and pc_write_enable SHALL never both be high in the same cycle.

Reset
REQ-032 While reset is high, all outputs SHALL be 0, IR=0, result=0, both flags=0 and state=FETCH.
REQ-033 Reset asserted mid-instruction SHALL abort it with no register write, and the first FETCH SHALL follow the clock edge after reset deasserts.

Verification
REQ-034 ROM 0:70 1:05 2:74 3:FB 4:21 5:F0 -> R0=05, R1=FB, R0=00 after ADD with zero_flag=1 and carry_flag=1; halted=1 at cycle 14.
REQ-035 SUB: R0=03, R1=05, instruction 0x31 -> R0=FE, carry_flag=1, zero_flag=0.
REQ-036 ROM of all NOP (00) -> pc stops at 06, one fetch at 06, then halted=1, and write_enable is never asserted.
REQ-037 LDI 0x70 at address PC_MAX -> halted=1 with no register write.
REQ-038 Reset pulse during EXECUTE of an ADD -> no write_enable pulse, and state=FETCH after release.
REQ-039 Opcode 0x9A -> behaves as NOP: 4 cycles, no write, flags unchanged.
